// File: rtl/mat_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mat_pkg: shared constants, state encoding and ASCII helpers for   |
// | the matrix result formatter.  Rev 1.0                             |
// +------------------------------------------------------------------+
package mat_pkg;

  localparam int MAX_DIM_DEF = 5;
  localparam int CNT_W       = 5;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_X     = 8'h78;
  localparam logic [7:0] ASCII_0     = 8'h30;

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_CAPTURE    = 4'd1,
`ifdef MAT_RESULT_HEADER_EN
    ST_HEADER     = 4'd2,
`endif
    ST_CONV       = 4'd3,
    ST_EMIT_FIELD = 4'd4,
    ST_EMIT_SEP   = 4'd5,
    ST_EMIT_CR    = 4'd6,
    ST_EMIT_LF    = 4'd7,
    ST_DONE       = 4'd8
  } state_e;

  // A blanked digit prints as a space so the field stays right-aligned.
  function automatic logic [7:0] digit_chr(input logic [3:0] d, input logic blank);
    return blank ? ASCII_SPACE : (ASCII_0 | {4'b0, d});
  endfunction

  function automatic logic [7:0] dim_chr(input logic [2:0] d);
    return ASCII_0 | {5'b0, d};
  endfunction

endpackage
`default_nettype wire

// File: rtl/mat_result_fmt_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mat_result_fmt_if: element capture stream plus UART byte          |
// | handshake and frame status for mat_result_fmt.  Rev 1.0           |
// +------------------------------------------------------------------+
interface mat_result_fmt_if;

  logic       frame_start;
  logic [2:0] dim_m;
  logic [2:0] dim_n;
  logic       in_valid;
  logic [7:0] in_data;
  logic       tx_ready;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       busy;
  logic       frame_done;
  logic       fmt_error;

  modport slave (
    input  frame_start, dim_m, dim_n, in_valid, in_data, tx_ready,
    output tx_valid, tx_data, busy, frame_done, fmt_error
  );

  modport master (
    output frame_start, dim_m, dim_n, in_valid, in_data, tx_ready,
    input  tx_valid, tx_data, busy, frame_done, fmt_error
  );

endinterface
`default_nettype wire

// File: rtl/mat_bin2dec.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mat_bin2dec: combinational 8-bit to 3-digit decimal with leading  |
// | zero blank flags (units digit is never blanked).  Rev 1.0         |
// +------------------------------------------------------------------+
module mat_bin2dec (
  input  wire logic [7:0] bin,
  output logic      [3:0] hund,
  output logic      [3:0] tens,
  output logic      [3:0] ones,
  output logic            blank_hund,
  output logic            blank_tens
);

  assign hund       = 4'(bin / 8'd100);
  assign tens       = 4'((bin / 8'd10) % 8'd10);
  assign ones       = 4'(bin % 8'd10);
  assign blank_hund = (hund == 4'd0);
  assign blank_tens = (hund == 4'd0) && (tens == 4'd0);

endmodule
`default_nettype wire

// File: rtl/mat_result_fmt.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mat_result_fmt: buffers a row-major result matrix, then prints it |
// | as 3-char right-aligned decimal fields with CR LF per row.        |
// | Optional MAT_RESULT_HEADER_EN prefixes an "MxN" CR LF line.       |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module mat_result_fmt
  import mat_pkg::*;
#(
  parameter int MAX_DIM = MAX_DIM_DEF,
  parameter int DATA_W  = 8
) (
  input wire logic         clk,
  input wire logic         rst_n,
  mat_result_fmt_if.slave  bus
);

  localparam int DEPTH = MAX_DIM * MAX_DIM;

  state_e             state_q, state_d;
  logic [2:0]         dim_m_q, dim_m_d;
  logic [2:0]         dim_n_q, dim_n_d;
  logic [CNT_W-1:0]   total_q, total_d;
  logic [CNT_W-1:0]   wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0]   rd_idx_q, rd_idx_d;
  logic [2:0]         col_q, col_d;
  logic [2:0]         byte_idx_q, byte_idx_d;
  logic [7:0]         tens_chr_q, tens_chr_d;
  logic [7:0]         units_chr_q, units_chr_d;
  logic               tx_valid_q, tx_valid_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               busy_q, busy_d;
  logic               frame_done_q, frame_done_d;
  logic               fmt_error_q, fmt_error_d;

  logic [DATA_W-1:0]  mem_q [DEPTH];
  logic               mem_we;

  logic               w_xfer;
  logic               w_bad_dims;
  logic [3:0]         w_hund, w_tens, w_ones;
  logic               w_blank_hund, w_blank_tens;

  mat_bin2dec u_bin2dec (
    .bin        (mem_q[rd_idx_q]),
    .hund       (w_hund),
    .tens       (w_tens),
    .ones       (w_ones),
    .blank_hund (w_blank_hund),
    .blank_tens (w_blank_tens)
  );

  assign w_xfer     = tx_valid_q && bus.tx_ready;
  assign w_bad_dims = (bus.dim_m == 3'd0) || (int'(bus.dim_m) > MAX_DIM) ||
                      (bus.dim_n == 3'd0) || (int'(bus.dim_n) > MAX_DIM);

  always_comb begin
    state_d      = state_q;
    dim_m_d      = dim_m_q;
    dim_n_d      = dim_n_q;
    total_d      = total_q;
    wr_cnt_d     = wr_cnt_q;
    rd_idx_d     = rd_idx_q;
    col_d        = col_q;
    byte_idx_d   = byte_idx_q;
    tens_chr_d   = tens_chr_q;
    units_chr_d  = units_chr_q;
    tx_valid_d   = tx_valid_q;
    tx_data_d    = tx_data_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
    fmt_error_d  = 1'b0;
    mem_we       = 1'b0;

    // A new frame request is only honoured from IDLE; anything else is an error.
    if (bus.frame_start && (state_q != ST_IDLE)) fmt_error_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (bus.frame_start) begin
          if (w_bad_dims) begin
            fmt_error_d = 1'b1;
          end else begin
            dim_m_d  = bus.dim_m;
            dim_n_d  = bus.dim_n;
            total_d  = CNT_W'({3'b0, bus.dim_m} * {3'b0, bus.dim_n});
            wr_cnt_d = '0;
            busy_d   = 1'b1;
            state_d  = ST_CAPTURE;
          end
        end
      end

      ST_CAPTURE: begin
        if (bus.in_valid) begin
          mem_we   = 1'b1;
          wr_cnt_d = wr_cnt_q + 5'd1;
          if (wr_cnt_q == total_q - 5'd1) begin
            rd_idx_d = '0;
            col_d    = '0;
`ifdef MAT_RESULT_HEADER_EN
            byte_idx_d = '0;
            tx_valid_d = 1'b1;
            tx_data_d  = dim_chr(dim_m_q);
            state_d    = ST_HEADER;
`else
            state_d    = ST_CONV;
`endif
          end
        end
      end

`ifdef MAT_RESULT_HEADER_EN
      ST_HEADER: begin
        if (w_xfer) begin
          byte_idx_d = byte_idx_q + 3'd1;
          case (byte_idx_q)
            3'd0:    tx_data_d = ASCII_X;
            3'd1:    tx_data_d = dim_chr(dim_n_q);
            3'd2:    tx_data_d = ASCII_CR;
            3'd3:    tx_data_d = ASCII_LF;
            default: begin
              tx_valid_d = 1'b0;
              state_d    = ST_CONV;
            end
          endcase
        end
      end
`endif

      ST_CONV: begin
        tens_chr_d  = digit_chr(w_tens, w_blank_tens);
        units_chr_d = digit_chr(w_ones, 1'b0);
        tx_data_d   = digit_chr(w_hund, w_blank_hund);
        tx_valid_d  = 1'b1;
        byte_idx_d  = '0;
        state_d     = ST_EMIT_FIELD;
      end

      ST_EMIT_FIELD: begin
        if (w_xfer) begin
          if (byte_idx_q == 3'd0) begin
            tx_data_d  = tens_chr_q;
            byte_idx_d = 3'd1;
          end else if (byte_idx_q == 3'd1) begin
            tx_data_d  = units_chr_q;
            byte_idx_d = 3'd2;
          end else if (col_q == dim_n_q - 3'd1) begin
            tx_data_d = ASCII_CR;
            state_d   = ST_EMIT_CR;
          end else begin
            tx_data_d = ASCII_SPACE;
            state_d   = ST_EMIT_SEP;
          end
        end
      end

      ST_EMIT_SEP: begin
        if (w_xfer) begin
          tx_valid_d = 1'b0;
          rd_idx_d   = rd_idx_q + 5'd1;
          col_d      = col_q + 3'd1;
          state_d    = ST_CONV;
        end
      end

      ST_EMIT_CR: begin
        if (w_xfer) begin
          tx_data_d = ASCII_LF;
          state_d   = ST_EMIT_LF;
        end
      end

      ST_EMIT_LF: begin
        if (w_xfer) begin
          tx_valid_d = 1'b0;
          col_d      = '0;
          if (rd_idx_q == total_q - 5'd1) begin
            frame_done_d = 1'b1;
            busy_d       = 1'b0;
            state_d      = ST_DONE;
          end else begin
            rd_idx_d = rd_idx_q + 5'd1;
            state_d  = ST_CONV;
          end
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      dim_m_q      <= '0;
      dim_n_q      <= '0;
      total_q      <= '0;
      wr_cnt_q     <= '0;
      rd_idx_q     <= '0;
      col_q        <= '0;
      byte_idx_q   <= '0;
      tens_chr_q   <= '0;
      units_chr_q  <= '0;
      tx_valid_q   <= 1'b0;
      tx_data_q    <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      fmt_error_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      dim_m_q      <= dim_m_d;
      dim_n_q      <= dim_n_d;
      total_q      <= total_d;
      wr_cnt_q     <= wr_cnt_d;
      rd_idx_q     <= rd_idx_d;
      col_q        <= col_d;
      byte_idx_q   <= byte_idx_d;
      tens_chr_q   <= tens_chr_d;
      units_chr_q  <= units_chr_d;
      tx_valid_q   <= tx_valid_d;
      tx_data_q    <= tx_data_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      fmt_error_q  <= fmt_error_d;
    end
  end

  // Element buffer carries no reset; its contents are rewritten every frame.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[wr_cnt_q] <= DATA_W'(bus.in_data);
  end

  assign bus.tx_valid   = tx_valid_q;
  assign bus.tx_data    = tx_data_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = frame_done_q;
  assign bus.fmt_error  = fmt_error_q;

endmodule
`default_nettype wire

// File: tb/tb_mat_result_fmt.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_mat_result_fmt: directed and randomized frames checked against |
// | a text-level model of the printed matrix.  Rev 1.0                |
// +------------------------------------------------------------------+
module tb_mat_result_fmt;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  mat_result_fmt_if bus ();

  mat_result_fmt #(.MAX_DIM(5), .DATA_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Text the frame should print: "%3d" fields, space separated, CR LF per row.
  function automatic string model(input int m, input int n, input logic [7:0] e[$]);
    string s = "";
`ifdef MAT_RESULT_HEADER_EN
    s = $sformatf("%0dx%0d\r\n", m, n);
`endif
    for (int r = 0; r < m; r++) begin
      for (int c = 0; c < n; c++) begin
        s = {s, $sformatf("%3d", e[r*n+c])};
        if (c == n - 1) s = {s, "\r\n"};
        else            s = {s, " "};
      end
    end
    return s;
  endfunction

  task automatic cmp_stream(input string tag, input string exp, input logic [7:0] got[$]);
    int bad = -1;
    int lim = (got.size() < exp.len()) ? got.size() : exp.len();
    chk({tag, "_len"}, got.size(), exp.len());
    for (int i = 0; i < lim; i++)
      if (bad < 0 && got[i] !== exp[i]) bad = i;
    checks++;
    assert (bad < 0) else begin
      failures++;
      $error("FAIL %s_bytes: byte %0d observed=%0h expected=%0h", tag, bad, got[bad], exp[bad]);
    end
  endtask

  task automatic send_frame(input int m, input int n, input logic [7:0] e[$],
                            input bit gaps, input string exp);
    bus.frame_start = 1'b1;
    bus.dim_m = 3'(m);
    bus.dim_n = 3'(n);
    @(posedge clk); #1;
    bus.frame_start = 1'b0;
    chk("busy_rise", bus.busy, 1);
    foreach (e[i]) begin
      while (gaps && ($urandom_range(2) == 0)) begin
        @(posedge clk); #1;
      end
      bus.in_valid = 1'b1;
      bus.in_data  = e[i];
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.in_data  = 8'($urandom);
    end
`ifdef MAT_RESULT_HEADER_EN
    chk("first_valid_t1", bus.tx_valid, 1);
    chk("first_byte", bus.tx_data, exp[0]);
`else
    chk("conv_idle_t1", bus.tx_valid, 0);
    @(posedge clk); #1;
    chk("first_valid_t2", bus.tx_valid, 1);
    chk("first_byte", bus.tx_data, exp[0]);
`endif
  endtask

  task automatic recv(input int exp_len, input int ready_pct, input int stall_byte,
                      input int stall_len, input int inject_at, input int abort_at,
                      output logic [7:0] got[$]);
    int n = 0;
    int stall_left = stall_len;
    bit done = 1'b0;
    bit injected = 1'b0;
    got = {};
    for (int cyc = 0; cyc < 4000 && !done; cyc++) begin
      bit rdy, xfer, stl, inj;
      logic [7:0] d;
      if (abort_at >= 0 && n == abort_at) break;
      rdy = ($urandom_range(99) < ready_pct);
      if (stall_left > 0 && n == stall_byte && bus.tx_valid) begin
        rdy = 1'b0;
        stall_left--;
      end
      inj = (inject_at >= 0 && n == inject_at && !injected);
      if (inj) begin
        bus.frame_start = 1'b1;
        bus.dim_m = 3'd2;
        bus.dim_n = 3'd2;
        injected = 1'b1;
      end
      bus.tx_ready = rdy;
      xfer = bus.tx_valid && rdy;
      stl  = bus.tx_valid && !rdy;
      d    = bus.tx_data;
      @(posedge clk); #1;
      bus.frame_start = 1'b0;
      if (inj) chk("fmt_err_midframe", bus.fmt_error, 1);
      if (stl) begin
        chk("stall_valid_held", bus.tx_valid, 1);
        chk("stall_data_stable", bus.tx_data, d);
      end
      if (xfer) begin
        got.push_back(d);
        n++;
        if (n == exp_len) begin
          chk("done_after_lf", bus.frame_done, 1);
          chk("busy_fall", bus.busy, 0);
          done = 1'b1;
        end
      end else if (bus.frame_done) begin
        done = 1'b1;
      end
    end
    bus.tx_ready = 1'b0;
    if (abort_at < 0) chk("recv_complete", done, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] e[$];
    logic [7:0] got[$];
    string exp;
    int m, n;

    bus.frame_start = 1'b0;
    bus.dim_m = 3'd0;
    bus.dim_n = 3'd0;
    bus.in_valid = 1'b0;
    bus.in_data = 8'd0;
    bus.tx_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx_valid", bus.tx_valid, 0);
    chk("rst_tx_data", bus.tx_data, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_frame_done", bus.frame_done, 0);
    chk("rst_fmt_error", bus.fmt_error, 0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // 2x2 with tx_ready held high
    e = '{8'd1, 8'd23, 8'd255, 8'd0};
    exp = model(2, 2, e);
    send_frame(2, 2, e, 1'b0, exp);
    recv(exp.len(), 100, -1, 0, -1, -1, got);
    cmp_stream("f2x2", exp, got);
    chk("done_pulse_end", bus.frame_done, 1);
    @(posedge clk); #1;
    chk("done_one_cycle", bus.frame_done, 0);

    // Same frame, stalled for 3 cycles in the middle of the first field
    send_frame(2, 2, e, 1'b0, exp);
    recv(exp.len(), 100, 1, 3, -1, -1, got);
    cmp_stream("f2x2_stall", exp, got);
    @(posedge clk); #1;

    // Rejected dimensions
    bus.tx_ready = 1'b1;
    bus.frame_start = 1'b1; bus.dim_m = 3'd0; bus.dim_n = 3'd3;
    @(posedge clk); #1;
    bus.frame_start = 1'b0;
    chk("err_0x3", bus.fmt_error, 1);
    chk("err_0x3_busy", bus.busy, 0);
    @(posedge clk); #1;
    chk("err_pulse_len", bus.fmt_error, 0);
    bus.frame_start = 1'b1; bus.dim_m = 3'd6; bus.dim_n = 3'd1;
    @(posedge clk); #1;
    bus.frame_start = 1'b0;
    chk("err_6x1", bus.fmt_error, 1);
    chk("err_6x1_busy", bus.busy, 0);
    for (int i = 0; i < 6; i++) begin
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      chk("rej_no_tx", bus.tx_valid, 0);
    end
    bus.in_valid = 1'b0;
    bus.tx_ready = 1'b0;

    // 5x5 with a frame_start attempt during emission
    e = {};
    for (int i = 0; i < 25; i++) e.push_back(8'($urandom));
    exp = model(5, 5, e);
    send_frame(5, 5, e, 1'b1, exp);
    recv(exp.len(), 100, -1, 0, 10, -1, got);
    cmp_stream("f5x5_inject", exp, got);
    @(posedge clk); #1;

    // Reset part-way through a 3x3 frame, then a 1x1 frame
    e = {};
    for (int i = 0; i < 9; i++) e.push_back(8'($urandom));
    exp = model(3, 3, e);
    send_frame(3, 3, e, 1'b0, exp);
    recv(exp.len(), 100, -1, 0, -1, 4, got);
    chk("abort_bytes", got.size(), 4);
    rst_n = 1'b0;
    #1;
    chk("abort_tx_valid", bus.tx_valid, 0);
    chk("abort_tx_data", bus.tx_data, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_frame_done", bus.frame_done, 0);
    chk("abort_fmt_error", bus.fmt_error, 0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    e = '{8'd100};
    exp = model(1, 1, e);
    send_frame(1, 1, e, 1'b0, exp);
    recv(exp.len(), 100, -1, 0, -1, -1, got);
    cmp_stream("f1x1", exp, got);
    @(posedge clk); #1;

    // Randomized frames with random ready throttling
    for (int k = 0; k < 8; k++) begin
      m = $urandom_range(5, 1);
      n = $urandom_range(5, 1);
      e = {};
      for (int i = 0; i < m * n; i++) e.push_back(8'($urandom));
      exp = model(m, n, e);
      send_frame(m, n, e, 1'b1, exp);
      recv(exp.len(), $urandom_range(100, 40), -1, 0, -1, -1, got);
      cmp_stream($sformatf("rand%0d_%0dx%0d", k, m, n), exp, got);
      @(posedge clk); #1;
    end

    chk("end_busy", bus.busy, 0);
    chk("end_tx_valid", bus.tx_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mat_result_fmt.md
# mat_result_fmt

Downstream stage of the matrix operation unit. Captures the result element stream (one 8-bit element per `in_valid` cycle, row-major) into a local buffer. Once the whole matrix is captured, it emits the matrix as ASCII text, one byte per handshake, to the UART transmitter. Each element is a right-aligned 3-character decimal field; each row ends with CR LF.

## Interface
- `MAX_DIM`, default 5: maximum rows/columns; buffer depth is `MAX_DIM*MAX_DIM`.
- `DATA_W`, default 8: element width. Only 8 is supported, since formatting is 3 decimal digits.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `frame_start` in 1: pulse; latches `dim_m`/`dim_n` and begins a capture.
- `dim_m` in 3: result rows.
- `dim_n` in 3: result columns.
- `in_valid` in 1: `in_data` carries the next element. There is no backpressure.
- `in_data` in 8: result element, unsigned.
- `tx_ready` in 1: UART transmitter can accept a byte.
- `tx_valid` out 1: `tx_data` is valid.
- `tx_data` out 8: ASCII byte.
- `busy` out 1: high from `frame_start` acceptance until `frame_done`.
- `frame_done` out 1: one-cycle pulse after the final LF transfers.
- `fmt_error` out 1: one-cycle pulse on a rejected frame or command.

## Operation
- States: IDLE, CAPTURE, HEADER (only when the macro is defined), CONV, EMIT_FIELD, EMIT_SEP, EMIT_CR, EMIT_LF, DONE.
- **IDLE:**
  - `frame_start` with `dim_m` or `dim_n` equal to 0, or greater than `MAX_DIM`, gives a `fmt_error` pulse and the block stays in IDLE.
  - Otherwise the block latches the dims, sets `total = m*n` (5-bit), clears `wr_cnt` and goes to CAPTURE.
  - `in_valid` is ignored in IDLE.
- **CAPTURE:**
  - Each `in_valid` writes `buf[wr_cnt]` and increments `wr_cnt`.
  - The write with `wr_cnt == total-1` moves the state to HEADER or CONV.
- **CONV:** registers the hundreds, tens and units digits of `buf[rd_idx]` from the `mat_bin2dec` outputs. Leading zeros become space (0x20); the units digit is always printed.
- **EMIT_FIELD:** sends 3 bytes (hundreds, tens, units).
  - If the column is not the last, go to EMIT_SEP and send space.
  - If the column is the last, go to EMIT_CR (0x0D), then EMIT_LF (0x0A).
- **After the separator or LF:**
  - Increment `rd_idx`.
  - If `rd_idx` was `total-1` after the LF, go to DONE.
  - Otherwise go to CONV.
- **DONE:** pulses `frame_done`, drops `busy` and returns to IDLE.
- **Column/row tracking:** column counter `col` wraps at `dim_n`. The row count is implied by `rd_idx`.
- **`frame_start` outside IDLE:** ignored and produces a `fmt_error` pulse; the current frame is unaffected.
- **`in_valid` outside CAPTURE:** dropped silently.
- **Byte handshake:**
  - A byte transfers on a rising edge with `tx_valid && tx_ready`.
  - Once raised, `tx_valid` stays high and `tx_data` stays stable until the transfer.
  - `tx_valid` never depends combinationally on `tx_ready`.

## Timing
- Reset values: `tx_valid`=0, `tx_data`=0x00, `busy`=0, `frame_done`=0, `fmt_error`=0, state=IDLE, all counters 0. Buffer contents are don't-care.
- `busy` rises the cycle after an accepted `frame_start`.
- Last element captured at edge t:
  - CONV occupies cycle t+1.
  - `tx_valid` is high from cycle t+2 with the first field byte.
- With `tx_ready` held high:
  - Bytes within a field and its separator/CR/LF go out back-to-back, one per cycle.
  - Each CONV inserts exactly one idle cycle between fields.
- `frame_done` fires the cycle after the final LF transfer. `busy` falls in that same cycle.
- Asserting `rst_n` mid-frame aborts immediately. No partial bytes are sent after release.

## Configuration
- `MAT_RESULT_HEADER_EN` defined:
  - After capture, the HEADER state first emits 5 bytes: ASCII `dim_m`, 'x', ASCII `dim_n`, CR, LF.
  - `tx_valid` then rises at t+1, and CONV follows the header's LF.
- Undefined: there is no HEADER state and the timing is as above.

## Structure
- Shared package `mat_pkg`:
  - ASCII constants: space, CR, LF, 'x', '0'.
  - State encoding typedef.
  - `MAX_DIM` default.
- Sub-module `mat_bin2dec`: combinational 8-bit to 3-digit BCD conversion, with a leading-zero blank flag per digit. Its output is registered in CONV.

## Test plan
- 2x2 frame [1,23,255,0], `tx_ready`=1 → bytes "  1  23\r\n255   0\r\n"; `frame_done` one cycle after the last LF.
- Same frame with `tx_ready` low for 3 cycles mid-field → `tx_data` stable while stalled; identical byte sequence; no loss or duplication.
- `frame_start` with dims 0x3, then 6x1 → `fmt_error` pulses twice, `tx_valid` never rises, `busy` stays 0.
- `frame_start` during emission of a 5x5 frame → `fmt_error` pulse; all 25 fields still emitted correctly.
- `rst_n` asserted after 4 bytes of a 3x3 frame → all outputs at reset values. A following 1x1 [100] frame yields "100\r\n".
- With `MAT_RESULT_HEADER_EN` defined, 1x3 [7,8,9] → "1x3\r\n  7   8   9\r\n"; `tx_valid` at t+1.
